regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter in front of a register file.
// Sweeps zeros into every register after reset or on clear_req.
module regfile_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_req,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          clear_busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          ptr_reg, ptr_next;
  logic          rf_we_reg, rf_we_next;
  logic [AW-1:0] rf_waddr_reg, rf_waddr_next;
  logic [DW-1:0] rf_wdata_reg, rf_wdata_next;
  logic [1:0]    valid;
  logic [1:0]    grant;
  logic          sel;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  assign valid    = {req1_valid, req0_valid};
  assign sel      = grant[1];
  assign sel_addr = sel ? req1_addr : req0_addr;
  assign sel_data = sel ? req1_data : req0_data;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    ptr_next      = ptr_reg;
    rf_we_next    = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    grant         = 2'b00;
    case (state_reg)
      CLEAR: begin
        rf_we_next    = 1'b1;
        rf_waddr_next = cnt_reg;
        rf_wdata_next = '0;
        if (cnt_reg == {AW{1'b1}}) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + AW'(1);
        end
      end
      default: begin
        if (clear_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end else if (!reset) begin
          // Reset gating keeps readys low while reset overrides the grant.
          if (valid == 2'b11) grant = ptr_reg ? 2'b10 : 2'b01;
          else                grant = valid;
          if (grant != 2'b00) begin
            ptr_next = ~sel;
            // x0 is hard-wired: the transfer is accepted but never written.
            if (sel_addr != '0) begin
              rf_we_next    = 1'b1;
              rf_waddr_next = sel_addr;
              rf_wdata_next = sel_data;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CLEAR;
      cnt_reg      <= '0;
      ptr_reg      <= 1'b0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ptr_reg      <= ptr_next;
      rf_we_reg    <= rf_we_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rf_we      = rf_we_reg;
  assign rf_waddr   = rf_waddr_reg;
  assign rf_wdata   = rf_wdata_reg;
  assign clear_busy = (state_reg == CLEAR);

endmodule
